mul_share_ctrl: RTL and testbench

- Round-robin scheduler that shares one serial shift-add Q8.8 multiplier (16-bit operands, 16-bit result, sticky out_stb, synchronous active-high restart) among NREQ requesters, e.g. FFT8 twiddle multiplies.
- Arbitrates requests, holds operands stable for the whole multiply, and restarts the multiplier through its reset input.
- Captures the result on the multiplier strobe and returns it with the requester index over a valid/ready response channel.

---
 rtl/mul_share_ctrl.sv | 150 +++++++++++++++
 tb/tb_mul_share_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin front end that time-shares one serial Q8.8
// shift-add multiplier among NREQ requesters. Operands are held stable for
// the whole multiply, the multiplier is restarted through mul_rst, and the
// result is returned with the owner index over a response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The request side offers a one-hot req_ready only in IDLE.
// The response side holds rsp_valid, rsp_data, rsp_id and rsp_err stable
// until rsp_ready is seen. rsp_ready without rsp_valid has no effect.
module mul_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_rst,
    input  logic [W-1:0]      mul_out,
    input  logic              mul_stb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              busy,
    output logic              err_sticky,
    output logic [1:0]        state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [IDW-1:0] rr_ptr;
    logic [TW-1:0]  timer;
    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic [W-1:0]   sel_a, sel_b;
    logic           accept;
    logic           timeout_hit;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!sel_found && req_valid[cand[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    assign accept      = (state == S_IDLE) && sel_found;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    // One-hot grant, only offered in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && rst) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Next-state logic; a strobe wins over a coincident timeout.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (sel_found) state_d = S_RUN;
            S_RUN:  if (mul_stb || timeout_hit) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand, timer and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= IDW'(NREQ - 1);
            timer      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_rst    <= 1'b1;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state   <= state_d;
            // Multiplier runs only while we are in RUN.
            mul_rst <= (state_d != S_RUN);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a  <= sel_a;
                        mul_b  <= sel_b;
                        rsp_id <= sel_idx;
                        rr_ptr <= sel_idx;
                        timer  <= '0;
                    end
                end
                S_RUN: begin
                    timer <= timer + TW'(1);
                    if (mul_stb) begin
                        rsp_data <= mul_out;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Testbench for mul_share_ctrl with a behavioural serial-multiplier stand-in,
// a round-robin reference model and an expected-result queue.
module tb_mul_share_ctrl;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_rst;
    logic [W-1:0]      mul_out;
    logic              mul_stb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic              busy;
    logic              err_sticky;
    logic [1:0]        state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int rr_m     = NREQ - 1;
    bit err_m    = 1'b0;
    bit stb_kill = 1'b0;
    logic [W-1:0] exp_q[$];

    mul_share_ctrl #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst),
        .mul_out(mul_out), .mul_stb(mul_stb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .err_sticky(err_sticky), .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Q8.8 product with truncation, from plain integer arithmetic.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = (int'($signed(a)) * int'($signed(b))) >>> 8;
        return p[W-1:0];
    endfunction

    // Round-robin reference: first valid index after ptr, modulo NREQ.
    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        logic [NREQ-1:0] s;
        for (int k = 1; k <= NREQ; k++) begin
            s = v >> ((ptr + k) % NREQ);
            if (s[0]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Serial multiplier stand-in: 16 working edges after restart, then a sticky strobe.
    logic [4:0] m_cnt;
    logic       m_stb;
    logic [W-1:0] m_out;
    always @(posedge clk) begin
        if (mul_rst) begin
            m_cnt <= '0;
            m_stb <= 1'b0;
            m_out <= '0;
        end else if (m_cnt != 5'd16) begin
            m_cnt <= m_cnt + 5'd1;
            if (m_cnt == 5'd15 && !stb_kill) begin
                m_stb <= 1'b1;
                m_out <= ref_mul(mul_a, mul_b);
            end
        end
    end
    assign mul_stb = m_stb;
    assign mul_out = m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        check("rst_mul_rst", 32'(mul_rst), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err_sticky", 32'(err_sticky), 0);
    endtask

    // Drive one request pattern, follow it through RUN and RESP.
    task automatic run_one(input logic [NREQ-1:0] valid, input bit kill, input int hold,
                           input bit fixed, input logic [W-1:0] fa, input logic [W-1:0] fb,
                           input bit chk_gap);
        logic [NREQ*W-1:0] pa, pb;
        logic [W-1:0] ea, eb, ed;
        int g, lat;
        for (int i = 0; i < NREQ; i++) begin
            pa[i*W +: W] = fixed ? fa : W'($urandom);
            pb[i*W +: W] = fixed ? fb : W'($urandom);
        end
        req_a = pa; req_b = pb; req_valid = valid; stb_kill = kill;
        #1;
        g = exp_grant(valid, rr_m);
        ea = '0; eb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == g) begin
                ea = pa[i*W +: W];
                eb = pb[i*W +: W];
            end
        end
        check("idle_req_ready", 32'(req_ready), 32'(NREQ'(1) << g));
        check("idle_mul_rst", 32'(mul_rst), 1);
        @(posedge clk); #1;
        if (chk_gap) check("grant_spacing", 32'(cyc - last_acc), 19);
        last_acc = cyc;
        rr_m = g;
        exp_q.push_back(kill ? '0 : ref_mul(ea, eb));
        if (kill) err_m = 1'b1;
        check("run_req_ready", 32'(req_ready), 0);
        check("run_mul_rst", 32'(mul_rst), 0);
        check("run_busy", 32'(busy), 1);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        rsp_ready = 1'b0;
        ed = exp_q.pop_front();
        check("latency", 32'(lat), kill ? TIMEOUT : 17);
        check("rsp_data", 32'(rsp_data), 32'(ed));
        if (!kill) check("rsp_vs_mul_out", 32'(rsp_data), 32'(mul_out));
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_err", 32'(rsp_err), 32'(kill));
        check("err_sticky", 32'(err_sticky), 32'(err_m));
        check("resp_mul_rst", 32'(mul_rst), 1);
        check("resp_mul_a", 32'(mul_a), 32'(ea));
        check("resp_mul_b", 32'(mul_b), 32'(eb));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 1);
            check("hold_rsp_data", 32'(rsp_data), 32'(ed));
            check("hold_rsp_id", 32'(rsp_id), 32'(g));
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_mul_rst", 32'(mul_rst), 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 0);
        check("post_busy", 32'(busy), 0);
        check("post_mul_a", 32'(mul_a), 32'(ea));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", 32'(rsp_valid), 0);

        // Single request, directed operands: 2.0 * 1.5 = 3.0.
        run_one(4'b0001, 1'b0, 0, 1'b1, 16'h0200, 16'h0180, 1'b0);
        check("single_result_const", 32'(ref_mul(16'h0200, 16'h0180)), 32'h0300);

        // Fairness with all requesters pending and rsp_ready immediate.
        for (int n = 0; n < 6; n++) run_one(4'b1111, 1'b0, 0, 1'b0, '0, '0, n > 0);

        // Backpressure for 10 cycles with other requests pending.
        run_one(4'b0110, 1'b0, 10, 1'b0, '0, '0, 1'b0);
        run_one(4'b0110, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Sign pass-through.
        run_one(4'b1000, 1'b0, 0, 1'b1, 16'hFE00, 16'h0100, 1'b0);

        // Timeout, then good multiplies keep err_sticky set.
        run_one(4'b0101, 1'b1, 2, 1'b0, '0, '0, 1'b0);
        run_one(4'b1010, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_one(4'b0011, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Random patterns and backpressure.
        for (int n = 0; n < 8; n++)
            run_one(NREQ'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 4), 1'b0, '0, '0, 1'b0);

        // Reset in RUN cycle 8: no response, round-robin pointer restarts.
        req_a = {NREQ{16'h0300}}; req_b = {NREQ{16'h0100}};
        req_valid = 4'b0001; stb_kill = 1'b0;
        @(posedge clk); #1;
        repeat (7) begin @(posedge clk); #1; end
        check("pre_reset_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset_vals();
        rr_m = NREQ - 1; err_m = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_rsp_after_reset", 32'(rsp_valid), 0);
        end
        run_one(4'b1100, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
